// File: rtl/ram_bist_if.sv
// Single-port ram access bundle: address/select/operation/wdata driven by the
// initiator, rdata returned by the ram.
interface ram_bist_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 20
);
   logic [AW-1:0] ram_address;
   logic          ram_select;
   logic          ram_operation;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      output ram_address,
      output ram_select,
      output ram_operation,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_address,
      input  ram_select,
      input  ram_operation,
      input  ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_bist.sv
// Ram built-in self-test: writes seed^address to every word, reads each back,
// and reports pass, a saturating error count and the first failing address.
module ram_bist #(
   parameter int unsigned word_size   = 20,
   parameter int unsigned word_amount = 30,
   parameter int unsigned err_width   = 8,
   localparam int unsigned AW = (word_amount > 1) ? $clog2(word_amount) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [word_size-1:0] seed,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [err_width-1:0] err_count,
   output logic [AW-1:0]        first_err_addr,
   ram_bist_if.master           ram
);

   localparam int unsigned MW = (AW > word_size) ? AW : word_size;

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_ACCESS,
      RD_SETUP,
      RD_ACCESS,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [word_size-1:0]  seed_q, seed_d;
   logic [err_width-1:0]  err_q, err_d;
   logic [AW-1:0]         first_q, first_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [AW-1:0]         ram_addr_q, ram_addr_d;
   logic                  ram_sel_q, ram_sel_d;
   logic                  ram_op_q, ram_op_d;
   logic [word_size-1:0]  ram_wd_q, ram_wd_d;
   logic                  last_addr;

   // Test pattern: seed xor zero-extended address, truncated to the word.
   function automatic logic [word_size-1:0] pat(input logic [word_size-1:0] s,
                                                input logic [AW-1:0] a);
      logic [MW-1:0] ext;
      ext = MW'(a);
      return s ^ word_size'(ext);
   endfunction

   assign last_addr = (addr_q == AW'(word_amount - 1));

   // Next state plus registered-output values derived from the next state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      seed_d  = seed_q;
      err_d   = err_q;
      first_d = first_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               seed_d  = seed;
               err_d   = '0;
               first_d = '0;
               addr_d  = '0;
               state_d = WR_SETUP;
            end
         end
         WR_SETUP: state_d = WR_ACCESS;
         WR_ACCESS: begin
            if (last_addr) begin
               addr_d  = '0;
               state_d = RD_SETUP;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = WR_SETUP;
            end
         end
         RD_SETUP: state_d = RD_ACCESS;
         RD_ACCESS: begin
            if (ram.ram_rdata != pat(seed_q, addr_q)) begin
               if (err_q != '1) err_d = err_q + err_width'(1);
               if (err_q == '0) first_d = addr_q;
            end
            if (last_addr) begin
               addr_d  = '0;
               state_d = DONE;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = RD_SETUP;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d     = 1'b0;
      done_d     = 1'b0;
      ram_sel_d  = 1'b0;
      ram_op_d   = 1'b0;
      ram_addr_d = '0;
      ram_wd_d   = '0;

      case (state_d)
         WR_SETUP, WR_ACCESS: begin
            busy_d     = 1'b1;
            ram_op_d   = 1'b1;
            ram_addr_d = addr_d;
            ram_wd_d   = pat(seed_d, addr_d);
            ram_sel_d  = (state_d == WR_ACCESS);
         end
         RD_SETUP, RD_ACCESS: begin
            busy_d     = 1'b1;
            ram_addr_d = addr_d;
            ram_sel_d  = (state_d == RD_ACCESS);
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase

      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         seed_q     <= '0;
         err_q      <= '0;
         first_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         ram_addr_q <= '0;
         ram_sel_q  <= 1'b0;
         ram_op_q   <= 1'b0;
         ram_wd_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         seed_q     <= seed_d;
         err_q      <= err_d;
         first_q    <= first_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         ram_addr_q <= ram_addr_d;
         ram_sel_q  <= ram_sel_d;
         ram_op_q   <= ram_op_d;
         ram_wd_q   <= ram_wd_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign pass              = pass_q;
   assign err_count         = err_q;
   assign first_err_addr    = first_q;
   assign ram.ram_address   = ram_addr_q;
   assign ram.ram_select    = ram_sel_q;
   assign ram.ram_operation = ram_op_q;
   assign ram.ram_wdata     = ram_wd_q;

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: fault-injecting ram model, protocol monitor,
// vector table, randomized stuck-at faults against a readback model, saturation unit.
`timescale 1ns/1ps
module tb_ram_bist;

   localparam int unsigned DW = 20;
   localparam int unsigned N  = 30;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start, busy, done, pass;
   logic [DW-1:0] seed;
   logic [7:0]    err_count;
   logic [AW-1:0] first_err_addr;

   logic          start2, busy2, done2, pass2;
   logic [DW-1:0] seed2;
   logic [1:0]    err2;
   logic [AW-1:0] first2;

   ram_bist_if #(.AW(AW), .DW(DW)) ram_if ();
   ram_bist_if #(.AW(AW), .DW(DW)) sat_if ();

   ram_bist #(.word_size(DW), .word_amount(N), .err_width(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .ram(ram_if)
   );

   ram_bist #(.word_size(DW), .word_amount(N), .err_width(2)) u_sat (
      .clk(clk), .rst(rst), .start(start2), .seed(seed2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_err_addr(first2),
      .ram(sat_if)
   );

   // Ram model with per-word stuck-at-1 / stuck-at-0 masks on readback.
   logic [DW-1:0] mem [N];
   logic [DW-1:0] s1  [N];
   logic [DW-1:0] s0  [N];
   logic [DW-1:0] rdata_c, sat_rd_c, sat_seed;

   always @(posedge clk)
      if (!rst && ram_if.ram_select && ram_if.ram_operation && (int'(ram_if.ram_address) < N))
         mem[ram_if.ram_address] <= ram_if.ram_wdata;

   always_comb begin
      rdata_c = '0;
      if (int'(ram_if.ram_address) < N)
         rdata_c = (mem[ram_if.ram_address] | s1[ram_if.ram_address]) & ~s0[ram_if.ram_address];
   end
   assign ram_if.ram_rdata = rdata_c;

   always_comb sat_rd_c = ~(sat_seed ^ DW'(sat_if.ram_address));
   assign sat_if.ram_rdata = sat_rd_c;

   int checks = 0;
   int passes = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Protocol monitor, sampled on the falling edge.
   logic [DW-1:0] exp_seed;
   int            prot_err = 0;
   logic [AW:0]   pulses[$];

   initial begin
      logic          p_valid, p_sel, p_op;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_wd;
      p_valid = 1'b0; p_sel = 1'b0; p_op = 1'b0; p_addr = '0; p_wd = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_valid = 1'b0;
            p_sel   = 1'b0;
         end else begin
            if (int'(ram_if.ram_address) >= N) begin
               prot_err++;
               $display("FAIL prot_range: address %0d", ram_if.ram_address);
            end
            if (ram_if.ram_select) begin
               if (!p_valid || p_sel || p_addr != ram_if.ram_address ||
                   p_op != ram_if.ram_operation || p_wd != ram_if.ram_wdata) begin
                  prot_err++;
                  $display("FAIL prot_setup: addr %0d op %0b no matching setup cycle",
                           ram_if.ram_address, ram_if.ram_operation);
               end
               if (ram_if.ram_operation && ram_if.ram_wdata != (exp_seed ^ DW'(ram_if.ram_address))) begin
                  prot_err++;
                  $display("FAIL prot_wdata: got %0h expected %0h", ram_if.ram_wdata,
                           exp_seed ^ DW'(ram_if.ram_address));
               end
               pulses.push_back({ram_if.ram_operation, ram_if.ram_address});
            end
            p_valid = 1'b1;
            p_sel   = ram_if.ram_select;
            p_op    = ram_if.ram_operation;
            p_addr  = ram_if.ram_address;
            p_wd    = ram_if.ram_wdata;
         end
      end
   end

   // Expected result from a written-then-read-back view of every word.
   function automatic void model(input logic [DW-1:0] s, output int e, output int f);
      logic [DW-1:0] w, r;
      e = 0;
      f = 0;
      for (int a = 0; a < int'(N); a++) begin
         w = s ^ DW'(a);
         r = (w | s1[a]) & ~s0[a];
         if (r != w) begin
            if (e == 0) f = a;
            e++;
         end
      end
      if (e > 255) e = 255;
   endfunction

   task automatic clear_faults();
      for (int a = 0; a < int'(N); a++) begin
         s1[a] = '0;
         s0[a] = '0;
      end
   endtask

   // Called #1 after an edge; start is accepted on the next edge.
   task automatic run(input logic [DW-1:0] s, input int pulse_at, output int lat);
      start    = 1'b1;
      seed     = s;
      exp_seed = s;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (lat == pulse_at) begin
            start = 1'b1;
            seed  = ~s;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic [DW-1:0] seed;
      int            word;
      logic [DW-1:0] m1;
      logic [DW-1:0] m0;
      int            e_err;
      int            e_first;
      int            e_pass;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, e, f, bad, found;

      vecs[0] = '{20'h55555, 0,  20'h00000, 20'h00000, 0, 0,  1};
      vecs[1] = '{20'h00000, 5,  20'h00008, 20'h00000, 1, 5,  0};
      vecs[2] = '{20'h00000, 7,  20'h00001, 20'h00000, 0, 0,  1};
      vecs[3] = '{20'hFFFFF, 29, 20'h00000, 20'h80000, 1, 29, 0};
      vecs[4] = '{20'hABCDE, 0,  20'h00000, 20'hFFFFF, 1, 0,  0};

      rst = 1'b1; start = 1'b0; seed = '0; start2 = 1'b0; seed2 = '0;
      sat_seed = '0; exp_seed = '0;
      clear_faults();
      for (int a = 0; a < int'(N); a++) mem[a] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_first", int'(first_err_addr), 0);
      check("rst_select", int'(ram_if.ram_select), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Clean run: latency, result and full access ordering.
      pulses.delete();
      run(20'h0000F, 0, lat);
      check("clean_latency", lat, 120);
      check("clean_pass", int'(pass), 1);
      check("clean_err", int'(err_count), 0);
      check("clean_busy", int'(busy), 0);
      check("clean_pulses", pulses.size(), 60);
      bad = 0;
      for (int i = 0; i < pulses.size(); i++) begin
         if (i < int'(N)) begin
            if (pulses[i] != {1'b1, AW'(i)}) bad++;
         end else if (pulses[i] != {1'b0, AW'(i - int'(N))}) bad++;
      end
      check("clean_order", bad, 0);
      check("done_addr", int'(ram_if.ram_address), 0);
      check("done_wdata", int'(ram_if.ram_wdata), 0);

      // Vector table; each run starts straight from DONE with start held.
      foreach (vecs[i]) begin
         clear_faults();
         s1[vecs[i].word] = vecs[i].m1;
         s0[vecs[i].word] = vecs[i].m0;
         run(vecs[i].seed, 0, lat);
         check($sformatf("vec%0d_latency", i), lat, 120);
         check($sformatf("vec%0d_err", i), int'(err_count), vecs[i].e_err);
         check($sformatf("vec%0d_first", i), int'(first_err_addr), vecs[i].e_first);
         check($sformatf("vec%0d_pass", i), int'(pass), vecs[i].e_pass);
      end
      clear_faults();

      // start pulsed mid-run must be ignored.
      run(20'h13579, 10, lat);
      check("midstart_latency", lat, 120);
      check("midstart_pass", int'(pass), 1);

      // start held in DONE restarts with the new seed.
      run(20'hABCDE, 0, lat);
      check("restart_latency", lat, 120);
      check("restart_pass", int'(pass), 1);

      // Random seeds with random stuck-at faults.
      for (int k = 0; k < 8; k++) begin
         logic [DW-1:0] rs;
         int nf, wa, wb;
         clear_faults();
         rs = DW'($urandom);
         nf = $urandom_range(0, 4);
         for (int j = 0; j < nf; j++) begin
            wa = $urandom_range(0, N - 1);
            wb = $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) s1[wa][wb] = 1'b1;
            else s0[wa][wb] = 1'b1;
         end
         model(rs, e, f);
         run(rs, 0, lat);
         check($sformatf("rand%0d_err", k), int'(err_count), e);
         check($sformatf("rand%0d_first", k), int'(first_err_addr), f);
         check($sformatf("rand%0d_pass", k), int'(pass), (e == 0) ? 1 : 0);
      end
      clear_faults();

      // 2-bit error counter against an always-wrong ram.
      sat_seed = 20'h2468A;
      start2 = 1'b1;
      seed2  = sat_seed;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      check("sat_latency", lat, 120);
      check("sat_err", int'(err2), 3);
      check("sat_first", int'(first2), 0);
      check("sat_pass", int'(pass2), 0);

      // Reset in the middle of a write access.
      start = 1'b1; seed = 20'h0F0F0; exp_seed = 20'h0F0F0;
      @(posedge clk); #1;
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(posedge clk); #1;
         if (ram_if.ram_select && ram_if.ram_operation) found = 1;
      end
      check("rst_found_wracc", found, 1);
      rst = 1'b1;
      #1;
      check("midrst_select", int'(ram_if.ram_select), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_err", int'(err_count), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst_hold_select", int'(ram_if.ram_select), 0);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("postrst_busy", int'(busy), 0);
      check("postrst_done", int'(done), 0);
      check("postrst_select", int'(ram_if.ram_select), 0);

      check("protocol", prot_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
